difftest_commit_tracker: RTL and testbench
==========================================

// Module: difftest_commit_tracker
// PURPOSE
//  Sits between cpu_top debug_commit_* outputs and the difftest DPI modules (DifftestInstrCommit,
//  DifftestTrapEvent) in SimTop. Registers the commit stream one stage, keeps 64-bit cycle and
//  instruction counters, and detects halt or hang. Presents a sticky trap event with pc and code
//  so the simulator ends cleanly. Replaces the ad-hoc counters and delay registers in SimTop.
// PARAMETERS
//  HALT_INSTR       32'h5000_0000  encoding treated as program end (LoongArch "b 0" self-loop)
//  WATCHDOG_CYCLES  10000          cycles with no commit before a hang trap; must be >= 1
//  DRAIN_CYCLES     2              cycles between halt detection and trap_valid; 0 allowed
// PORTS
//  clock          in   1    system clock
//  reset          in   1    asynchronous reset, active-high
//  commit_valid   in   1    one instruction retires this cycle
//  commit_pc      in   32   pc of the retiring instruction (`RegBus)
//  commit_instr   in   32   instruction word (`InstBus)
//  commit_wreg    in   1    retiring instruction writes a GPR
//  commit_waddr   in   5    destination GPR (`RegAddrBus)
//  commit_wdata   in   32   value written
//  gpr_a0         in   32   architectural r4 (debug_reg[159:128]); sampled at halt for the code
//  dt_valid       out  1    registered commit valid to DifftestInstrCommit
//  dt_pc          out  32   registered pc
//  dt_instr       out  32   registered instruction
//  dt_wen         out  1    registered write-enable
//  dt_wdest       out  5    registered dest
//  dt_wdata       out  32   registered wdata
//  cycle_cnt      out  64   cycles since reset release
//  instr_cnt      out  64   committed instructions
//  trap_valid     out  1    sticky trap indication
//  trap_code      out  3    0 GOOD, 1 BAD (a0!=0), 2 HANG
//  trap_pc        out  32   pc of the halt instruction, or last committed pc for a hang
// BEHAVIOUR
//  - Reset: all outputs 0. FSM = RUN. Watchdog and drain counters = 0. Async assert, sync release.
//  - dt_* = commit_* delayed exactly 1 cycle. In RUN and DRAIN, dt_valid = commit_valid of the prior cycle.
//  - In TRAP, dt_valid is forced 0. dt_* data fields keep their last values.
//  - cycle_cnt: +1 every cycle in RUN and DRAIN. Frozen in TRAP. Wraps mod 2^64, with no saturation.
//  - instr_cnt: +1 on each cycle with commit_valid in RUN, including the halt commit itself.
//    Frozen in DRAIN and TRAP.
//  - Watchdog: 32-bit count, cleared on commit_valid, else +1 in RUN.
//    Reaching WATCHDOG_CYCLES-1 with no commit that cycle -> HANG.
//  - FSM states and transitions:
//    RUN  : commit_valid && commit_instr==HALT_INSTR -> latch trap_pc=commit_pc.
//           Latch code = (gpr_a0==0)?0:1.
//           If DRAIN_CYCLES==0 go TRAP, else go DRAIN with drain_cnt=0.
//           Watchdog expiry -> latch trap_pc=last committed pc (0 if none yet), code=2 -> TRAP.
//           Halt commit and watchdog expiry in the same cycle: halt wins.
//    DRAIN: drain_cnt +1 per cycle. At DRAIN_CYCLES-1 -> TRAP. Commits are still forwarded on dt_*.
//           A second HALT_INSTR is ignored.
//    TRAP : terminal. trap_valid=1, trap_code and trap_pc held. Left only by reset.
//  - trap_valid is a registered output: asserted the cycle after entering TRAP.
//    Latency from the halt commit edge to trap_valid = DRAIN_CYCLES+1.
//  - Reset mid-DRAIN or in TRAP: everything returns to reset values and counting restarts.
//  - gpr_a0 is sampled in the same cycle as the halt commit. Any later change is ignored.
// STRUCTURE
//  - Width macros come from vsrc/defines.v (`RegBus, `InstBus, `RegAddrBus).
//  - TRAP_GOOD/BAD/HANG codes and the FSM state encodings go in the same shared defines file.
//  - One flat module. The watchdog is a simple counter and gets no sub-module.
//  - SimTop instantiates it under `ifdef DIFFTEST and wires trap_* and counters to DifftestTrapEvent.
// TESTING
//  1. Reset, 5 commits (pc 0x1c000000..0x1c000010), no halt -> dt_valid pulses 1 cycle late.
//     instr_cnt=5, cycle_cnt equals elapsed cycles, trap_valid=0.
//  2. Commit HALT_INSTR at pc 0x1c000040 with gpr_a0=0, DRAIN=2 -> trap_valid rises 3 edges later.
//     trap_code=0, trap_pc=0x1c000040. Counters are frozen afterwards.
//  3. Halt with gpr_a0=0x7 -> trap_code=1. Further commits give dt_valid=0 once in TRAP.
//  4. WATCHDOG_CYCLES=16, last commit pc 0x1c000008, then idle -> HANG after 16 idle cycles.
//     trap_code=2, trap_pc=0x1c000008.
//  5. Halt commit on the exact watchdog-expiry cycle -> trap_code=0/1 (halt wins), never 2.
//  6. Assert reset during DRAIN -> all outputs 0 immediately. After release, counting resumes from 0
//     and no trap is pending.

Source files
------------

// File: rtl/difftest_commit_tracker_pkg.sv
// Shared widths, FSM encoding, trap codes and commit payload for the
// difftest commit tracker.
package difftest_commit_tracker_pkg;

    localparam int unsigned XLEN        = 32;  // register / pc width
    localparam int unsigned ILEN        = 32;  // instruction word width
    localparam int unsigned RADDR_W     = 5;   // GPR address width
    localparam int unsigned CNT_W       = 64;  // cycle / instruction counters
    localparam int unsigned WDOG_W      = 32;  // watchdog counter
    localparam int unsigned DRAIN_W     = 32;  // drain counter
    localparam int unsigned TRAP_CODE_W = 3;

    // LoongArch "b 0" self-loop marks program end.
    localparam logic [ILEN-1:0] HALT_INSTR_DEF = 32'h5000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TRAP  = 2'd2
    } state_e;

    typedef enum logic [TRAP_CODE_W-1:0] {
        TRAP_GOOD = 3'd0,
        TRAP_BAD  = 3'd1,
        TRAP_HANG = 3'd2
    } trap_code_e;

    // One retiring instruction as seen by DifftestInstrCommit.
    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [ILEN-1:0]    instr;
        logic               wen;
        logic [RADDR_W-1:0] wdest;
        logic [XLEN-1:0]    wdata;
    } commit_t;

endpackage

// File: rtl/difftest_commit_tracker.sv
// Difftest commit tracker: registers the core's commit stream one stage for
// the difftest DPI modules, keeps 64-bit cycle / instruction counters and
// raises a sticky trap (GOOD / BAD / HANG) with its pc so simulation ends.
//
// Ports:
//   clock, reset             clock, asynchronous active-high reset
//   commit_*                 retiring instruction from the core
//   gpr_a0                   architectural r4, sampled on the halt commit
//   dt_*                     commit stream delayed one cycle
//   cycle_cnt, instr_cnt     cycles since reset / committed instructions
//   trap_valid/code/pc       sticky trap indication and its payload
module difftest_commit_tracker
    import difftest_commit_tracker_pkg::*;
#(
    parameter logic [ILEN-1:0] HALT_INSTR      = HALT_INSTR_DEF,
    parameter int unsigned     WATCHDOG_CYCLES = 10000,
    parameter int unsigned     DRAIN_CYCLES    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   commit_valid,
    input  logic [XLEN-1:0]        commit_pc,
    input  logic [ILEN-1:0]        commit_instr,
    input  logic                   commit_wreg,
    input  logic [RADDR_W-1:0]     commit_waddr,
    input  logic [XLEN-1:0]        commit_wdata,
    input  logic [XLEN-1:0]        gpr_a0,
    output logic                   dt_valid,
    output logic [XLEN-1:0]        dt_pc,
    output logic [ILEN-1:0]        dt_instr,
    output logic                   dt_wen,
    output logic [RADDR_W-1:0]     dt_wdest,
    output logic [XLEN-1:0]        dt_wdata,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       instr_cnt,
    output logic                   trap_valid,
    output logic [TRAP_CODE_W-1:0] trap_code,
    output logic [XLEN-1:0]        trap_pc
);

    // Terminal counts; guarded so a zero parameter cannot underflow.
    localparam logic [WDOG_W-1:0] WDOG_LAST =
        WDOG_W'((WATCHDOG_CYCLES == 32'd0) ? 32'd0 : WATCHDOG_CYCLES - 32'd1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST =
        DRAIN_W'((DRAIN_CYCLES == 32'd0) ? 32'd0 : DRAIN_CYCLES - 32'd1);

    state_e              state_q, state_d;
    commit_t             commit_c;
    commit_t             dt_q, dt_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [CNT_W-1:0]    instr_q, instr_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic [XLEN-1:0]     last_pc_q, last_pc_d;
    logic [XLEN-1:0]     trap_pc_q, trap_pc_d;
    trap_code_e          trap_code_q, trap_code_d;
    logic                trap_valid_q, trap_valid_d;

    logic                halt_hit_c;
    logic                wdog_hit_c;

    // Pack the incoming commit into the bus payload.
    always_comb begin
        commit_c       = '0;
        commit_c.valid = commit_valid;
        commit_c.pc    = commit_pc;
        commit_c.instr = commit_instr;
        commit_c.wen   = commit_wreg;
        commit_c.wdest = commit_waddr;
        commit_c.wdata = commit_wdata;
    end

    assign halt_hit_c = commit_valid && (commit_instr == HALT_INSTR);
    // A commit in the expiry cycle always rescues it, so halt beats hang.
    assign wdog_hit_c = !commit_valid && (wdog_q == WDOG_LAST);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (halt_hit_c) begin
                    state_d = (DRAIN_CYCLES == 32'd0) ? ST_TRAP : ST_DRAIN;
                end else if (wdog_hit_c) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_TRAP;
                end
            end
            ST_TRAP:  state_d = ST_TRAP;
            default:  state_d = ST_RUN;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        dt_d         = dt_q;
        cycle_d      = cycle_q;
        instr_d      = instr_q;
        wdog_d       = wdog_q;
        drain_d      = drain_q;
        last_pc_d    = last_pc_q;
        trap_pc_d    = trap_pc_q;
        trap_code_d  = trap_code_q;
        trap_valid_d = (state_q == ST_TRAP);

        if (commit_valid) begin
            wdog_d = '0;
        end

        case (state_q)
            ST_RUN: begin
                dt_d    = commit_c;
                cycle_d = cycle_q + CNT_W'(1);
                if (commit_valid) begin
                    instr_d   = instr_q + CNT_W'(1);
                    last_pc_d = commit_pc;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
                // a0 is captured here only; later changes do not matter.
                if (halt_hit_c) begin
                    trap_pc_d   = commit_pc;
                    trap_code_d = (gpr_a0 == '0) ? TRAP_GOOD : TRAP_BAD;
                    drain_d     = '0;
                end else if (wdog_hit_c) begin
                    trap_pc_d   = last_pc_q;
                    trap_code_d = TRAP_HANG;
                end
            end
            ST_DRAIN: begin
                // Commits still flow to difftest; second halts are ignored.
                dt_d    = commit_c;
                cycle_d = cycle_q + CNT_W'(1);
                drain_d = drain_q + DRAIN_W'(1);
            end
            ST_TRAP: begin
                dt_d.valid = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dt_q         <= '0;
            cycle_q      <= '0;
            instr_q      <= '0;
            wdog_q       <= '0;
            drain_q      <= '0;
            last_pc_q    <= '0;
            trap_pc_q    <= '0;
            trap_code_q  <= TRAP_GOOD;
            trap_valid_q <= 1'b0;
        end else begin
            dt_q         <= dt_d;
            cycle_q      <= cycle_d;
            instr_q      <= instr_d;
            wdog_q       <= wdog_d;
            drain_q      <= drain_d;
            last_pc_q    <= last_pc_d;
            trap_pc_q    <= trap_pc_d;
            trap_code_q  <= trap_code_d;
            trap_valid_q <= trap_valid_d;
        end
    end

    assign dt_valid   = dt_q.valid;
    assign dt_pc      = dt_q.pc;
    assign dt_instr   = dt_q.instr;
    assign dt_wen     = dt_q.wen;
    assign dt_wdest   = dt_q.wdest;
    assign dt_wdata   = dt_q.wdata;
    assign cycle_cnt  = cycle_q;
    assign instr_cnt  = instr_q;
    assign trap_valid = trap_valid_q;
    assign trap_code  = trap_code_q;
    assign trap_pc    = trap_pc_q;

endmodule

// File: tb/tb_difftest_commit_tracker.sv
// Testbench for difftest_commit_tracker: a fixed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_difftest_commit_tracker;

    localparam logic [31:0] HALT  = 32'h5000_0000;
    localparam logic [31:0] NOP   = 32'h0280_0c0c;
    localparam int          WDOG  = 16;
    localparam int          DRAIN = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = '0;
    logic [31:0] commit_instr = '0;
    logic        commit_wreg = 1'b0;
    logic [4:0]  commit_waddr = '0;
    logic [31:0] commit_wdata = '0;
    logic [31:0] gpr_a0 = '0;
    logic        dt_valid;
    logic [31:0] dt_pc;
    logic [31:0] dt_instr;
    logic        dt_wen;
    logic [4:0]  dt_wdest;
    logic [31:0] dt_wdata;
    logic [63:0] cycle_cnt;
    logic [63:0] instr_cnt;
    logic        trap_valid;
    logic [2:0]  trap_code;
    logic [31:0] trap_pc;

    difftest_commit_tracker #(
        .HALT_INSTR      (HALT),
        .WATCHDOG_CYCLES (WDOG),
        .DRAIN_CYCLES    (DRAIN)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_instr (commit_instr),
        .commit_wreg  (commit_wreg),
        .commit_waddr (commit_waddr),
        .commit_wdata (commit_wdata),
        .gpr_a0       (gpr_a0),
        .dt_valid     (dt_valid),
        .dt_pc        (dt_pc),
        .dt_instr     (dt_instr),
        .dt_wen       (dt_wen),
        .dt_wdest     (dt_wdest),
        .dt_wdata     (dt_wdata),
        .cycle_cnt    (cycle_cnt),
        .instr_cnt    (instr_cnt),
        .trap_valid   (trap_valid),
        .trap_code    (trap_code),
        .trap_pc      (trap_pc)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    bit              m_halted, m_trapped, m_trap_valid;
    int              m_drain_left, m_idle;
    longint unsigned m_cycles, m_instrs;
    logic [31:0]     m_last_pc, m_trap_pc;
    logic [2:0]      m_trap_code;
    logic            m_dt_valid, m_dt_wen;
    logic [31:0]     m_dt_pc, m_dt_instr, m_dt_wdata;
    logic [4:0]      m_dt_wdest;

    task automatic model_reset();
        m_halted = 0; m_trapped = 0; m_trap_valid = 0;
        m_drain_left = 0; m_idle = 0;
        m_cycles = 0; m_instrs = 0;
        m_last_pc = '0; m_trap_pc = '0; m_trap_code = '0;
        m_dt_valid = 0; m_dt_wen = 0; m_dt_pc = '0; m_dt_instr = '0;
        m_dt_wdata = '0; m_dt_wdest = '0;
    endtask

    // Effect of one clock edge given the inputs present during that cycle.
    task automatic model_step();
        if (!m_trapped) begin
            m_dt_valid = commit_valid;
            m_dt_pc    = commit_pc;
            m_dt_instr = commit_instr;
            m_dt_wen   = commit_wreg;
            m_dt_wdest = commit_waddr;
            m_dt_wdata = commit_wdata;
            m_cycles++;
            if (!m_halted && commit_valid) m_instrs++;
        end else begin
            m_dt_valid = 1'b0;
        end
        m_trap_valid = m_trapped;
        if (!m_halted && !m_trapped) begin
            if (commit_valid && commit_instr == HALT) begin
                m_halted     = 1;
                m_trap_pc    = commit_pc;
                m_trap_code  = (gpr_a0 == 0) ? 3'd0 : 3'd1;
                m_drain_left = DRAIN;
                if (DRAIN == 0) m_trapped = 1;
            end else if (commit_valid) begin
                m_idle    = 0;
                m_last_pc = commit_pc;
            end else begin
                m_idle++;
                if (m_idle == WDOG) begin
                    m_trapped   = 1;
                    m_trap_code = 3'd2;
                    m_trap_pc   = m_last_pc;
                end
            end
        end else if (m_halted && !m_trapped) begin
            m_drain_left--;
            if (m_drain_left == 0) m_trapped = 1;
        end
    endtask

    task automatic check_all();
        chk("dt_valid",   dt_valid,   m_dt_valid);
        chk("dt_pc",      dt_pc,      m_dt_pc);
        chk("dt_instr",   dt_instr,   m_dt_instr);
        chk("dt_wen",     dt_wen,     m_dt_wen);
        chk("dt_wdest",   dt_wdest,   m_dt_wdest);
        chk("dt_wdata",   dt_wdata,   m_dt_wdata);
        chk("cycle_cnt",  cycle_cnt,  m_cycles);
        chk("instr_cnt",  instr_cnt,  m_instrs);
        chk("trap_valid", trap_valid, m_trap_valid);
        chk("trap_code",  trap_code,  m_trap_code);
        chk("trap_pc",    trap_pc,    m_trap_pc);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic cv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] a0);
        commit_valid = cv;
        commit_pc    = pc;
        commit_instr = ins;
        commit_wreg  = pc[2];
        commit_waddr = pc[6:2];
        commit_wdata = pc ^ 32'h5a5a_0000;
        gpr_a0       = a0;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, gpr_a0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        gpr_a0 = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        cv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] a0;
        logic        e_dtv;
        int          e_ic;
        int          e_cc;
        logic        e_tv;
        logic [31:0] e_tpc;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n;
        logic [31:0] rpc;

        // cv  pc            instr a0  dtv ic cc tv trap_pc
        tbl[0]  = '{1'b1, 32'h1c00_0000, NOP,  0, 1'b1, 1, 1,  1'b0, 32'h0};
        tbl[1]  = '{1'b1, 32'h1c00_0004, NOP,  0, 1'b1, 2, 2,  1'b0, 32'h0};
        tbl[2]  = '{1'b1, 32'h1c00_0008, NOP,  0, 1'b1, 3, 3,  1'b0, 32'h0};
        tbl[3]  = '{1'b1, 32'h1c00_000c, NOP,  0, 1'b1, 4, 4,  1'b0, 32'h0};
        tbl[4]  = '{1'b1, 32'h1c00_0010, NOP,  0, 1'b1, 5, 5,  1'b0, 32'h0};
        tbl[5]  = '{1'b0, 32'h0,         NOP,  0, 1'b0, 5, 6,  1'b0, 32'h0};
        tbl[6]  = '{1'b1, 32'h1c00_0040, HALT, 0, 1'b1, 6, 7,  1'b0, 32'h1c00_0040};
        tbl[7]  = '{1'b0, 32'h0,         NOP,  0, 1'b0, 6, 8,  1'b0, 32'h1c00_0040};
        tbl[8]  = '{1'b1, 32'h1c00_0044, NOP,  0, 1'b1, 6, 9,  1'b0, 32'h1c00_0040};
        tbl[9]  = '{1'b1, 32'h1c00_0048, NOP,  0, 1'b0, 6, 9,  1'b1, 32'h1c00_0040};
        tbl[10] = '{1'b0, 32'h0,         NOP,  0, 1'b0, 6, 9,  1'b1, 32'h1c00_0040};

        // Reset state.
        do_reset();
        chk("rst_trap_valid", trap_valid, 0);
        chk("rst_cycle_cnt",  cycle_cnt,  0);

        // Normal commits, halt, drain, trap.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].cv, tbl[i].pc, tbl[i].ins, tbl[i].a0);
            tick();
            chk($sformatf("tbl%0d_dt_valid", i),   dt_valid,   tbl[i].e_dtv);
            chk($sformatf("tbl%0d_instr_cnt", i),  instr_cnt,  64'(tbl[i].e_ic));
            chk($sformatf("tbl%0d_cycle_cnt", i),  cycle_cnt,  64'(tbl[i].e_cc));
            chk($sformatf("tbl%0d_trap_valid", i), trap_valid, tbl[i].e_tv);
            chk($sformatf("tbl%0d_trap_code", i),  trap_code,  0);
            chk($sformatf("tbl%0d_trap_pc", i),    trap_pc,    tbl[i].e_tpc);
            if (tbl[i].e_dtv) chk($sformatf("tbl%0d_dt_pc", i), dt_pc, tbl[i].pc);
        end

        // Bad trap: a0 != 0 at the halt, then a0 changes and commits continue.
        do_reset();
        drive(1'b1, 32'h1c00_0000, NOP, 0);  tick();
        drive(1'b1, 32'h1c00_0004, NOP, 0);  tick();
        drive(1'b1, 32'h1c00_0080, HALT, 32'h7); tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h1c00_0084 + 32'(4 * i), NOP, 0);
            tick();
        end
        chk("bad_trap_valid", trap_valid, 1);
        chk("bad_trap_code",  trap_code,  1);
        chk("bad_trap_pc",    trap_pc,    32'h1c00_0080);
        chk("bad_dt_valid",   dt_valid,   0);
        chk("bad_instr_cnt",  instr_cnt,  3);

        // Hang: watchdog fires after WDOG idle cycles.
        do_reset();
        drive(1'b1, 32'h1c00_0000, NOP, 0); tick();
        drive(1'b1, 32'h1c00_0004, NOP, 0); tick();
        drive(1'b1, 32'h1c00_0008, NOP, 0); tick();
        idle();
        n = 0;
        while (!trap_valid && n < 40) begin
            tick();
            n++;
        end
        chk("hang_timeout",   32'(trap_valid), 1);
        chk("hang_latency",   32'(n), WDOG + 1);
        chk("hang_trap_code", trap_code, 2);
        chk("hang_trap_pc",   trap_pc,   32'h1c00_0008);
        chk("hang_instr_cnt", instr_cnt, 3);

        // Halt commit on the exact watchdog-expiry cycle.
        do_reset();
        drive(1'b1, 32'h1c00_0000, NOP, 0); tick();
        idle();
        repeat (WDOG - 1) tick();
        chk("edge_no_trap_yet", trap_valid, 0);
        drive(1'b1, 32'h1c00_0100, HALT, 0); tick();
        idle();
        n = 0;
        while (!trap_valid && n < 10) begin
            tick();
            n++;
        end
        chk("edge_timeout",   32'(trap_valid), 1);
        chk("edge_trap_code", trap_code, 0);
        chk("edge_trap_pc",   trap_pc,   32'h1c00_0100);

        // Reset asserted during DRAIN.
        do_reset();
        drive(1'b1, 32'h1c00_0000, NOP, 0);  tick();
        drive(1'b1, 32'h1c00_0040, HALT, 0); tick();
        idle(); tick();
        reset = 1'b1;
        #1;
        chk("rdrain_dt_valid",   dt_valid,   0);
        chk("rdrain_dt_pc",      dt_pc,      0);
        chk("rdrain_cycle_cnt",  cycle_cnt,  0);
        chk("rdrain_instr_cnt",  instr_cnt,  0);
        chk("rdrain_trap_valid", trap_valid, 0);
        chk("rdrain_trap_code",  trap_code,  0);
        chk("rdrain_trap_pc",    trap_pc,    0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rdrain_resume_cycle", cycle_cnt, 64'(i + 1));
            chk("rdrain_resume_trap",  trap_valid, 0);
        end

        // Randomized traffic; some rounds are sparse enough to hang.
        for (int r = 0; r < 8; r++) begin
            int pct;
            pct = (r == 3 || r == 6) ? 4 : 40 + 8 * r;
            do_reset();
            rpc = 32'h1c00_0000;
            for (int c = 0; c < 80; c++) begin
                if ($urandom_range(99) < pct) begin
                    logic [31:0] ins;
                    ins = ($urandom_range(99) < 4) ? HALT : $urandom;
                    if (ins == HALT && c < 10) ins = NOP;
                    rpc = rpc + 32'd4;
                    commit_valid = 1'b1;
                    commit_pc    = rpc;
                    commit_instr = ins;
                    commit_wreg  = 1'($urandom_range(1));
                    commit_waddr = 5'($urandom);
                    commit_wdata = $urandom;
                end else begin
                    commit_valid = 1'b0;
                    commit_pc    = $urandom;
                    commit_instr = $urandom;
                    commit_wreg  = 1'($urandom_range(1));
                    commit_waddr = 5'($urandom);
                    commit_wdata = $urandom;
                end
                gpr_a0 = ($urandom_range(1) == 0) ? 32'h0 : $urandom;
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
